// File: rtl/add_loa_pipe.sv
// add_loa_pipe: two-stage pipelined lower-part-OR approximate adder.
// Each transaction selects the exact or the approximate sum. A built-in
// monitor reports |exact - approx| per result and keeps error statistics.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends on in_valid. out_valid, O and O_err stay
// stable while out_valid is high and out_ready is low.
module add_loa_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4,
  parameter int CNT_W       = 16,
  parameter int ACC_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             exact_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   O,
  output logic [WIDTH:0]   O_err,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_count,
  output logic [ACC_W-1:0] stat_sum,
  output logic [WIDTH:0]   stat_max
);

  localparam int OW = WIDTH + 1;

  // Stage 1: operands and mode
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_mode_q;

  // Stage 2: result, error and valid
  logic             s2_valid_q;
  logic [OW-1:0]    s2_o_q;
  logic [OW-1:0]    s2_err_q;

  // Statistics
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [OW-1:0]    max_q, max_d;

  // Combinational results computed from stage 1
  logic [OW-1:0]    a_ext, b_ext;
  logic [OW-1:0]    exact_sum;
  logic [OW-1:0]    approx_low;
  logic [OW-1:0]    hi_sum;
  logic [OW-1:0]    approx_sum;
  logic [OW-1:0]    abs_diff;
  logic             cin;
  logic [OW-1:0]    o_d;
  logic [OW-1:0]    err_d;

  logic             adv;
  logic             complete;
  logic [ACC_W:0]   sum_ext;

  // A stalled output stage freezes the whole pipe, so bubbles are never squeezed out.
  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = adv;
  assign complete = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign O          = s2_o_q;
  assign O_err      = s2_err_q;
  assign stat_count = cnt_q;
  assign stat_sum   = sum_q;
  assign stat_max   = max_q;

  // Exact and lower-part-OR sums plus their absolute difference.
  always_comb begin
    a_ext      = {1'b0, s1_a_q};
    b_ext      = {1'b0, s1_b_q};
    exact_sum  = a_ext + b_ext;
    approx_low = '0;
    cin        = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < APPROX_BITS) approx_low[i] = s1_a_q[i] | s1_b_q[i];
      // Carry into the exact upper part is the AND of the top OR'd bit pair.
      if (i == APPROX_BITS - 1) cin = s1_a_q[i] & s1_b_q[i];
    end
    // Upper part fits in WIDTH-APPROX_BITS+1 bits, so shifting back up loses nothing.
    hi_sum     = (a_ext >> APPROX_BITS) + (b_ext >> APPROX_BITS) + OW'(cin);
    approx_sum = (hi_sum << APPROX_BITS) | approx_low;
    abs_diff   = (exact_sum >= approx_sum) ? (exact_sum - approx_sum)
                                           : (approx_sum - exact_sum);
    if (s1_mode_q) begin
      o_d   = exact_sum;
      err_d = '0;
    end else begin
      o_d   = approx_sum;
      err_d = abs_diff;
    end
  end

  // Both stages shift together on adv; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_o_q     <= '0;
      s2_err_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_a_q     <= A;
      s1_b_q     <= B;
      s1_mode_q  <= exact_mode;
      s2_valid_q <= s1_valid_q;
      s2_o_q     <= o_d;
      s2_err_q   <= err_d;
    end
  end

  // Next statistics: saturating count and sum, running maximum; clear wins over completion.
  always_comb begin
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    max_d   = max_q;
    sum_ext = {1'b0, sum_q} + {1'b0, ACC_W'(s2_err_q)};
    if (stat_clr) begin
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
    end else if (complete) begin
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (s2_err_q > max_q) max_d = s2_err_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

endmodule

// File: tb/tb_add_loa_pipe.sv
// tb_add_loa_pipe: directed vectors for add_loa_pipe with hand-computed results.
// A second instance with a 2-bit transaction counter shares all inputs and is
// used for the count saturation check.
module tb_add_loa_pipe;

  localparam int W = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus
  logic         in_valid;
  logic [W-1:0] a_in, b_in;
  logic         exact_mode;
  logic         out_ready;
  logic         stat_clr;

  // Main instance outputs
  logic         in_ready;
  logic         out_valid;
  logic [W:0]   o_out, o_err;
  logic [15:0]  stat_count;
  logic [23:0]  stat_sum;
  logic [W:0]   stat_max;

  // Saturation instance outputs
  logic         in_ready2;
  logic         out_valid2;
  logic [W:0]   o_out2, o_err2;
  logic [1:0]   stat_count2;
  logic [23:0]  stat_sum2;
  logic [W:0]   stat_max2;

  add_loa_pipe #(.WIDTH(8), .APPROX_BITS(4), .CNT_W(16), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .exact_mode(exact_mode),
    .out_valid(out_valid), .out_ready(out_ready), .O(o_out), .O_err(o_err),
    .stat_clr(stat_clr), .stat_count(stat_count), .stat_sum(stat_sum),
    .stat_max(stat_max)
  );

  add_loa_pipe #(.WIDTH(8), .APPROX_BITS(4), .CNT_W(2), .ACC_W(24)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .A(a_in), .B(b_in), .exact_mode(exact_mode),
    .out_valid(out_valid2), .out_ready(out_ready), .O(o_out2), .O_err(o_err2),
    .stat_clr(stat_clr), .stat_count(stat_count2), .stat_sum(stat_sum2),
    .stat_max(stat_max2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stream vectors: operands, mode, expected O and O_err
  logic [W-1:0] va[4], vb[4];
  logic         vm[4];
  logic [W:0]   vo[4], ve[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic m);
    in_valid   = v;
    a_in       = a;
    b_in       = b;
    exact_mode = m;
  endtask

  // One isolated op: accepted on the first edge, result visible after the second.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    drive(1'b1, a, b, m);
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic [W:0] o, input logic [W:0] e);
    va[i] = a; vb[i] = b; vm[i] = m; vo[i] = o; ve[i] = e;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; stat_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_O", 32'(o_out), 32'd0);
    chk("rst_O_err", 32'(o_err), 32'd0);
    chk("rst_count", 32'(stat_count), 32'd0);
    chk("rst_sum", 32'(stat_sum), 32'd0);
    chk("rst_max", 32'(stat_max), 32'd0);

    // Approximate mode
    run_one(8'h0F, 8'h01, 1'b0);
    chk("ap1_valid", 32'(out_valid), 32'd1);
    chk("ap1_O", 32'(o_out), 32'h00F);
    chk("ap1_err", 32'(o_err), 32'd1);
    run_one(8'hFF, 8'hFF, 1'b0);
    chk("ap2_O", 32'(o_out), 32'h1FF);
    chk("ap2_err", 32'(o_err), 32'd1);
    chk("ap2_count", 32'(stat_count), 32'd1);
    chk("ap2_sum", 32'(stat_sum), 32'd1);
    step();
    chk("ap_idle", 32'(out_valid), 32'd0);
    chk("ap_count", 32'(stat_count), 32'd2);
    chk("ap_sum", 32'(stat_sum), 32'd2);
    chk("ap_max", 32'(stat_max), 32'd1);

    // Exact mode
    run_one(8'hFF, 8'h01, 1'b1);
    chk("ex_O", 32'(o_out), 32'h100);
    chk("ex_err", 32'(o_err), 32'd0);
    step();
    chk("ex_count", 32'(stat_count), 32'd3);
    chk("ex_sum", 32'(stat_sum), 32'd2);

    // Back-to-back stream, mixed modes
    set_vec(0, 8'h0F, 8'h01, 1'b0, 9'h00F, 9'd1);
    set_vec(1, 8'h03, 8'h03, 1'b0, 9'h003, 9'd3);
    set_vec(2, 8'h02, 8'h02, 1'b0, 9'h002, 9'd2);
    set_vec(3, 8'h10, 8'h20, 1'b1, 9'h030, 9'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, va[i], vb[i], vm[i]);
      else in_valid = 1'b0;
      step();
      if (i >= 1 && i <= 4) begin
        chk($sformatf("str_valid%0d", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("str_O%0d", i - 1), 32'(o_out), 32'(vo[i - 1]));
        chk($sformatf("str_err%0d", i - 1), 32'(o_err), 32'(ve[i - 1]));
      end
    end
    chk("str_idle", 32'(out_valid), 32'd0);
    chk("str_count", 32'(stat_count), 32'd7);
    chk("str_sum", 32'(stat_sum), 32'd8);
    chk("str_max", 32'(stat_max), 32'd3);

    // Backpressure with a full pipe
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    step();
    drive(1'b1, 8'h0F, 8'h01, 1'b1);
    step();
    out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_rdy%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_O%0d", i), 32'(o_out), 32'h001);
      chk($sformatf("bp_hold_err%0d", i), 32'(o_err), 32'd1);
    end
    chk("bp_hold_count", 32'(stat_count), 32'd7);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_r1_O", 32'(o_out), 32'h010);
    chk("bp_r1_err", 32'(o_err), 32'd0);
    step();
    chk("bp_r2_valid", 32'(out_valid), 32'd1);
    chk("bp_r2_O", 32'(o_out), 32'h1FF);
    chk("bp_r2_err", 32'(o_err), 32'd1);
    step();
    chk("bp_idle", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(stat_count), 32'd10);
    chk("bp_sum", 32'(stat_sum), 32'd10);
    chk("bp_max", 32'(stat_max), 32'd3);

    // Statistics clear, then clear colliding with a completion
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_count", 32'(stat_count), 32'd0);
    chk("clr_sum", 32'(stat_sum), 32'd0);
    chk("clr_max", 32'(stat_max), 32'd0);
    set_vec(0, 8'h0F, 8'h01, 1'b0, 9'h00F, 9'd1);
    set_vec(1, 8'h03, 8'h03, 1'b0, 9'h003, 9'd3);
    set_vec(2, 8'h02, 8'h02, 1'b0, 9'h002, 9'd2);
    set_vec(3, 8'hFF, 8'hFF, 1'b0, 9'h1FF, 9'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, va[i], vb[i], vm[i]);
      else in_valid = 1'b0;
      if (i == 5) stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      if (i == 4) begin
        chk("st_count", 32'(stat_count), 32'd3);
        chk("st_sum", 32'(stat_sum), 32'd6);
        chk("st_max", 32'(stat_max), 32'd3);
        chk("st_O4", 32'(o_out), 32'h1FF);
      end
    end
    chk("stclr_count", 32'(stat_count), 32'd0);
    chk("stclr_sum", 32'(stat_sum), 32'd0);
    chk("stclr_max", 32'(stat_max), 32'd0);
    chk("stclr_pipe", 32'(out_valid), 32'd0);

    // Count saturation on the 2-bit counter instance
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(1'b1, 8'h01, 8'h01, 1'b0);
      else in_valid = 1'b0;
      step();
    end
    chk("sat_count2", 32'(stat_count2), 32'd3);
    chk("sat_count", 32'(stat_count), 32'd5);
    chk("sat_sum", 32'(stat_sum), 32'd5);
    chk("sat_max", 32'(stat_max), 32'd1);

    // Reset mid-stream drops in-flight work and clears stats
    drive(1'b1, 8'h0F, 8'h01, 1'b0);
    step();
    drive(1'b1, 8'h03, 8'h03, 1'b0);
    step();
    chk("mid_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(stat_count), 32'd0);
    chk("mid_rst_sum", 32'(stat_sum), 32'd0);
    chk("mid_rst_max", 32'(stat_max), 32'd0);
    chk("mid_rst_count2", 32'(stat_count2), 32'd0);
    step();
    chk("mid_rst_drop", 32'(out_valid), 32'd0);

    // Reset during a stall drops the held result
    run_one(8'h02, 8'h02, 1'b0);
    out_ready = 1'b0;
    step();
    chk("stall_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("stall_rst_valid", 32'(out_valid), 32'd0);
    chk("stall_rst_O", 32'(o_out), 32'd0);
    chk("stall_rst_count", 32'(stat_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
